// File: rtl/if_else_parser.sv
// rtl/if_else_parser.sv - streaming parser/evaluator for "if(x<cmp>V)begin p<=C1;end else begin p<=C2;end"
//
// Purpose:
//   Consumes 7-bit ASCII characters one at a time, checks the fixed construct
//   above, evaluates the condition against x when ')' is accepted, and loads
//   p with C1 or C2 when the final "end" completes.
//
// Parameters:
//   WIDTH         width of x, p and every parsed decimal literal
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   x             value tested by the condition, sampled when ')' is accepted
//   ascii_char    character code
//   char_valid    level strobe; one character is accepted per rising edge of it
//   p             result register
//   parsing_done  sticky, construct parsed without error
//   error_flag    sticky, syntax error detected
//
// Optional feature:
//   SIGNED_CMP_EN defined  -> x and V are compared as signed two's-complement
//   SIGNED_CMP_EN undefined -> unsigned comparison

module if_else_parser #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [6:0]       ascii_char,
    input  logic             char_valid,
    output logic [WIDTH-1:0] p,
    output logic             parsing_done,
    output logic             error_flag
);

    typedef enum logic [2:0] {
        ST_FIX,   // matching fixed keyword/punctuation text
        ST_CMP,   // expecting the first comparator character
        ST_CMP2,  // expecting the second comparator char (or a digit after < / >)
        ST_LIT,   // accumulating a decimal literal
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [2:0] {
        OP_EQ, OP_NE, OP_LT, OP_LE, OP_GT, OP_GE
    } op_t;

    state_t           state;
    op_t              op;
    logic [4:0]       pos;        // character index into the fixed text
    logic [1:0]       lit_sel;    // 0: V, 1: C1, 2: C2
    logic [WIDTH-1:0] acc;        // literal accumulator; still holds C2 at completion
    logic [WIDTH-1:0] c1;
    logic             has_digit;
    logic             ws_seen;    // whitespace arrived after at least one digit
    logic             cond;
    logic             valid_q;

    logic             accept;
    logic             is_ws;
    logic             is_digit;
    logic [6:0]       term_char;
    logic [WIDTH-1:0] digit_val;
    logic [WIDTH-1:0] acc_next;
    logic             x_lt_v;
    logic             x_eq_v;
    logic             cond_now;

    // The fixed text with all optional whitespace removed. Positions 3, 11
    // and 26 hand over to the comparator/literal states; position 29 is the
    // final 'd'.
    function automatic logic [7:0] fix_char(input logic [4:0] i);
        case (i)
            5'd0:  fix_char = "i";
            5'd1:  fix_char = "f";
            5'd2:  fix_char = "(";
            5'd3:  fix_char = "x";
            5'd4:  fix_char = "b";
            5'd5:  fix_char = "e";
            5'd6:  fix_char = "g";
            5'd7:  fix_char = "i";
            5'd8:  fix_char = "n";
            5'd9:  fix_char = "p";
            5'd10: fix_char = "<";
            5'd11: fix_char = "=";
            5'd12: fix_char = "e";
            5'd13: fix_char = "n";
            5'd14: fix_char = "d";
            5'd15: fix_char = "e";
            5'd16: fix_char = "l";
            5'd17: fix_char = "s";
            5'd18: fix_char = "e";
            5'd19: fix_char = "b";
            5'd20: fix_char = "e";
            5'd21: fix_char = "g";
            5'd22: fix_char = "i";
            5'd23: fix_char = "n";
            5'd24: fix_char = "p";
            5'd25: fix_char = "<";
            5'd26: fix_char = "=";
            5'd27: fix_char = "e";
            5'd28: fix_char = "n";
            5'd29: fix_char = "d";
            default: fix_char = 8'h00;
        endcase
    endfunction

    always_comb begin
        accept    = char_valid && !valid_q;
        is_ws     = (ascii_char == 7'h20) || (ascii_char == 7'h09) ||
                    (ascii_char == 7'h0A) || (ascii_char == 7'h0D);
        is_digit  = (ascii_char >= 7'h30) && (ascii_char <= 7'h39);
        term_char = (lit_sel == 2'd0) ? 7'h29 : 7'h3B;
        digit_val = {{(WIDTH-4){1'b0}}, ascii_char[3:0]};
        acc_next  = acc * WIDTH'(10) + digit_val;
`ifdef SIGNED_CMP_EN
        x_lt_v    = $signed(x) < $signed(acc);
`else
        x_lt_v    = x < acc;
`endif
        x_eq_v    = (x == acc);
        case (op)
            OP_EQ:   cond_now = x_eq_v;
            OP_NE:   cond_now = !x_eq_v;
            OP_LT:   cond_now = x_lt_v;
            OP_LE:   cond_now = x_lt_v || x_eq_v;
            OP_GT:   cond_now = !(x_lt_v || x_eq_v);
            OP_GE:   cond_now = !x_lt_v;
            default: cond_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_FIX;
            op           <= OP_EQ;
            pos          <= 5'd0;
            lit_sel      <= 2'd0;
            acc          <= '0;
            c1           <= '0;
            has_digit    <= 1'b0;
            ws_seen      <= 1'b0;
            cond         <= 1'b0;
            valid_q      <= 1'b0;
            p            <= '0;
            parsing_done <= 1'b0;
            error_flag   <= 1'b0;
        end else begin
            valid_q <= char_valid;
            if (accept) begin
                case (state)
                    ST_FIX: begin
                        if (!is_ws) begin
                            if ({1'b0, ascii_char} == fix_char(pos)) begin
                                pos <= pos + 5'd1;
                                if (pos == 5'd3) begin
                                    state <= ST_CMP;
                                end else if (pos == 5'd11 || pos == 5'd26) begin
                                    state     <= ST_LIT;
                                    lit_sel   <= (pos == 5'd11) ? 2'd1 : 2'd2;
                                    acc       <= '0;
                                    has_digit <= 1'b0;
                                    ws_seen   <= 1'b0;
                                end else if (pos == 5'd29) begin
                                    state        <= ST_DONE;
                                    p            <= cond ? c1 : acc;
                                    parsing_done <= 1'b1;
                                end
                            end else begin
                                state      <= ST_ERR;
                                error_flag <= 1'b1;
                            end
                        end
                    end

                    ST_CMP: begin
                        if (!is_ws) begin
                            state <= ST_CMP2;
                            case (ascii_char)
                                7'h3D:   op <= OP_EQ;
                                7'h21:   op <= OP_NE;
                                7'h3C:   op <= OP_LT;
                                7'h3E:   op <= OP_GT;
                                default: begin
                                    state      <= ST_ERR;
                                    error_flag <= 1'b1;
                                end
                            endcase
                        end
                    end

                    ST_CMP2: begin
                        if (!is_ws) begin
                            lit_sel <= 2'd0;
                            ws_seen <= 1'b0;
                            if (ascii_char == 7'h3D) begin
                                state     <= ST_LIT;
                                acc       <= '0;
                                has_digit <= 1'b0;
                                if (op == OP_LT) op <= OP_LE;
                                if (op == OP_GT) op <= OP_GE;
                            end else if (is_digit && (op == OP_LT || op == OP_GT)) begin
                                // strict < or >: this digit already belongs to V
                                state     <= ST_LIT;
                                acc       <= digit_val;
                                has_digit <= 1'b1;
                            end else begin
                                state      <= ST_ERR;
                                error_flag <= 1'b1;
                            end
                        end
                    end

                    ST_LIT: begin
                        if (is_digit) begin
                            if (ws_seen) begin
                                state      <= ST_ERR;
                                error_flag <= 1'b1;
                            end else begin
                                acc       <= acc_next;
                                has_digit <= 1'b1;
                            end
                        end else if (is_ws) begin
                            if (has_digit) ws_seen <= 1'b1;
                        end else if (ascii_char == term_char && has_digit) begin
                            state <= ST_FIX;
                            case (lit_sel)
                                2'd0: begin
                                    cond <= cond_now;
                                    pos  <= 5'd4;
                                end
                                2'd1: begin
                                    c1  <= acc;
                                    pos <= 5'd12;
                                end
                                default: pos <= 5'd27;
                            endcase
                        end else begin
                            state      <= ST_ERR;
                            error_flag <= 1'b1;
                        end
                    end

                    default: ; // ST_DONE / ST_ERR: sticky until reset
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_else_parser.sv
// tb/tb_if_else_parser.sv - directed self-checking bench for if_else_parser
module tb_if_else_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x = '0;
    logic [6:0]  ascii_char = '0;
    logic        char_valid = 1'b0;
    logic [31:0] p;
    logic        parsing_done;
    logic        error_flag;

    int total = 0;
    int bad   = 0;

    if_else_parser #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .x            (x),
        .ascii_char   (ascii_char),
        .char_valid   (char_valid),
        .p            (p),
        .parsing_done (parsing_done),
        .error_flag   (error_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        char_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Raises the strobe for 'hold' edges, then drops it for one edge.
    task automatic send_char(input byte c, input int hold);
        ascii_char = c[6:0];
        char_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1 char_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) send_char(s[i], hold);
    endtask

    function automatic string mk(input string cmp_v);
        return {"if(x", cmp_v, ")begin p<=20;endelsebegin p<=30;end"};
    endfunction

    task automatic run(input string tag, input logic [31:0] xv, input string s,
                       input int hold, input logic [31:0] exp_p);
        do_reset();
        x = xv;
        send_str(s, hold);
        check({tag, ".done"}, 32'(parsing_done), 32'd1);
        check({tag, ".err"},  32'(error_flag),   32'd0);
        check({tag, ".p"},    p,                 exp_p);
    endtask

    string s1;
    string s_pre;

    initial begin
        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst.p",    p,                 32'd0);
        check("rst.done", 32'(parsing_done), 32'd0);
        check("rst.err",  32'(error_flag),   32'd0);

        // scenario 1 with one-cycle latency check on the final 'd'
        s1 = mk(">=5");
        s_pre = s1.substr(0, s1.len() - 2);
        do_reset();
        x = 32'd6;
        send_str(s_pre, 2);
        check("s1.pre_done", 32'(parsing_done), 32'd0);
        check("s1.pre_p",    p,                 32'd0);
        ascii_char = 7'h64;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        check("s1.lat_done", 32'(parsing_done), 32'd1);
        check("s1.lat_p",    p,                 32'd20);
        check("s1.lat_err",  32'(error_flag),   32'd0);
        char_valid = 1'b0;
        @(posedge clk);
        #1;

        run("ge_x4", 32'd4, mk(">=5"), 2, 32'd30);
        run("ge_x5", 32'd5, mk(">=5"), 2, 32'd20);
        run("gt_x5", 32'd5, mk(">5"),  2, 32'd30);
        run("eq_x7", 32'd7, mk("==7"), 2, 32'd20);
        run("ne_x7", 32'd7, mk("!=7"), 2, 32'd30);
        run("lt_x3", 32'd3, mk("<7"),  2, 32'd20);
        run("le_sp", 32'd7, "if ( x < = 7 ) begin p <= 11 ; end else begin p <= 12 ; end", 1, 32'd11);
        run("wrap",  32'd0, "if(x<5)begin p<=4294967297;endelsebegin p<=30;end", 2, 32'd1);
        run("wrapv", 32'd0, mk("<4294967297"), 2, 32'd20);
        run("hold10", 32'd6, mk(">=5"), 10, 32'd20);
        run("hold1",  32'd6, mk(">=5"), 1,  32'd20);

        // syntax error: flag on the 'y' accepting edge, then sticky
        do_reset();
        x = 32'd6;
        send_str("if(", 2);
        ascii_char = 7'h79;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        check("err.edge",  32'(error_flag),   32'd1);
        check("err.done",  32'(parsing_done), 32'd0);
        check("err.p",     p,                 32'd0);
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        send_str("x>=5)begin p<=20;endelsebegin p<=30;end", 1);
        check("err.stick", 32'(error_flag),   32'd1);
        check("err.done2", 32'(parsing_done), 32'd0);
        check("err.p2",    p,                 32'd0);

        // further error cases
        do_reset();
        send_str("if(x>)", 1);
        check("err.cmp_rp", 32'(error_flag), 32'd1);
        do_reset();
        send_str("if(x>=)", 1);
        check("err.nolit", 32'(error_flag), 32'd1);
        do_reset();
        send_str("if(x>=5 5)", 1);
        check("err.dig_ws", 32'(error_flag), 32'd1);
        do_reset();
        send_str("if(x=<", 1);
        check("err.eq_lt", 32'(error_flag), 32'd1);

        // reset mid-stream, then a clean parse
        do_reset();
        x = 32'd6;
        send_str("if(x=", 1);
        do_reset();
        check("mid.p",    p,                 32'd0);
        check("mid.done", 32'(parsing_done), 32'd0);
        check("mid.err",  32'(error_flag),   32'd0);
        send_str(mk(">=5"), 2);
        check("mid.done2", 32'(parsing_done), 32'd1);
        check("mid.p2",    p,                 32'd20);

        // all-ones x against "<5"
`ifdef SIGNED_CMP_EN
        run("sgn", 32'hFFFF_FFFF, mk("<5"), 1, 32'd20);
`else
        run("sgn", 32'hFFFF_FFFF, mk("<5"), 1, 32'd30);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_else_parser.md
Name: if_else_parser

Overview:
Streaming character-level parser and evaluator for one fixed Verilog-like construct: "if(x<cmp><dec>)begin p<=<dec>;end else begin p<=<dec>;end".
- 7-bit ASCII characters arrive one at a time.
- The block evaluates the condition against live input x and drives p with the constant from the taken branch.
- It then raises parsing_done, or raises error_flag on any syntax violation.
- Used as a tiny hardware interpreter front end between a character source (UART/host) and downstream logic consuming p.

Parameters:
- WIDTH, 32, width of x, p and all parsed decimal literals.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- x  input  WIDTH  value tested by the condition; sampled when ')' is accepted.
- ascii_char  input  7  character code.
- char_valid  input  1  character strobe; a character is accepted only on the rising edge of this level.
- p  output  WIDTH  result register.
- parsing_done  output  1  sticky; construct fully parsed without error.
- error_flag  output  1  sticky; syntax error detected.

Behaviour:
- Only clock: clk. Reset rst is synchronous and active-high.
- Reset clears p=0, parsing_done=0, error_flag=0, and all state/accumulators. The char_valid history register resets to 0. Reset mid-stream aborts parsing completely.
- Accept rule: a character is consumed on the clk edge where char_valid=1 and its registered previous value was 0. A strobe held high for many cycles consumes exactly one character. The next character needs char_valid to return low first.
- Whitespace: space, 0x09, 0x0A and 0x0D are discarded in every state. Whitespace between keywords is optional ("endelse" is legal).
- Accepted characters are ignored once parsing_done=1 or error_flag=1. Both flags stay set until reset.
- Required token sequence (case-sensitive):
  - "if", "(", "x", comparator, literal V, ")"
  - "begin", "p", "<=", literal C1, ";", "end"
  - "else"
  - "begin", "p", "<=", literal C2, ";", "end"
- Keywords are matched with a per-keyword character index.
- Comparator:
  - First char is one of '=', '!', '<', '>'.
  - '=' must be followed by '='; '!' must be followed by '='.
  - '<' or '>' may be followed by '=' (giving <=, >=). Otherwise the next char is the first digit of V (giving strict < or >).
- Literals: unsigned decimal, at least 1 digit. acc <= acc*10 + digit, truncated to WIDTH (wraps mod 2^WIDTH).
  - A literal ends at the terminator (')' or ';') or at whitespace.
  - A digit after whitespace that followed a digit is an error.
- Condition: evaluated on the edge accepting ')', using the current x, unsigned comparison, stored in a cond bit.
- Completion: on the edge accepting the final 'd', p <= cond ? C1 : C2 and parsing_done <= 1, visible the cycle after that edge. p does not change at any other time.
- Error: any character not allowed in the current state (including a missing literal, or ')' right after a comparator) sets error_flag on the accepting edge. p keeps its value and parsing_done stays 0.
- Latency: one clock from the accepting edge to the flag or p update.

Optional Feature:
- Macro SIGNED_CMP_EN.
- Defined: x and V are compared as two's-complement signed WIDTH-bit values.
- Undefined: unsigned comparison as specified above.
- Parsing behaviour is identical either way.

Test Plan:
- x=6, stream "if(x>=5)begin p<=20;endelsebegin p<=30;end", each char with char_valid high for 2 cycles -> parsing_done=1, error_flag=0, p=20.
- Same stream with x=4 -> p=30, done=1. With x=5 -> p=20. With ">" instead of ">=" and x=5 -> p=30.
- "==7" with x=7 -> p=20. "!=7" with x=7 -> p=30. "<7" with x=3 -> p=20. Literal "4294967297" wraps to 1.
- "if(y" -> error_flag=1 on the 'y' accept edge, done=0, p=0. Further characters have no effect.
- char_valid held high 10 cycles per character -> each character counted once, same result as scenario 1. A single-cycle strobe also works.
- Assert rst after "if(x=" -> all outputs 0. A full subsequent stream parses correctly. Under SIGNED_CMP_EN, x=32'hFFFFFFFF with "<5" -> p=C1; without the macro -> p=C2.
